// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the memory unit.
//   unit_sel_t / word_t   : existing unit-interface types
//   MEM_OP_* / MEM_SIZE_* : unit_ctrl field encodings
//   MMIO_*_OFS            : register offsets inside the MMIO window
//   mem_state_t           : load-pipeline state
//   region_t              : address-decode result (REGION_NONE doubles as "faulted")
package mem_unit_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        UNIT_SEL_ALU    = 2'd0,
        UNIT_SEL_MEM    = 2'd1,
        UNIT_SEL_BRANCH = 2'd2,
        UNIT_SEL_NONE   = 2'd3
    } unit_sel_t;

    localparam logic [1:0] MEM_OP_NONE  = 2'd0;
    localparam logic [1:0] MEM_OP_READ  = 2'd1;
    localparam logic [1:0] MEM_OP_WRITE = 2'd2;

    localparam logic [2:0] MEM_SIZE_B  = 3'd0;
    localparam logic [2:0] MEM_SIZE_H  = 3'd1;
    localparam logic [2:0] MEM_SIZE_W  = 3'd2;
    localparam logic [2:0] MEM_SIZE_BU = 3'd4;
    localparam logic [2:0] MEM_SIZE_HU = 3'd5;

    localparam logic [3:0] MMIO_LED_OFS   = 4'h0;
    localparam logic [3:0] MMIO_CYCLE_OFS = 4'h4;

    typedef enum logic {
        IDLE,
        LOAD_PEND
    } mem_state_t;

    typedef enum logic [1:0] {
        REGION_NONE = 2'd0,
        REGION_RAM  = 2'd1,
        REGION_MMIO = 2'd2
    } region_t;

    function automatic logic size_is_byte(input logic [2:0] size);
        return (size == MEM_SIZE_B) || (size == MEM_SIZE_BU);
    endfunction

    function automatic logic size_is_half(input logic [2:0] size);
        return (size == MEM_SIZE_H) || (size == MEM_SIZE_HU);
    endfunction

    // Any size code that is neither byte nor half is a full-word access.
    function automatic logic [3:0] store_be(input logic [2:0] size, input logic [1:0] lo);
        if (size_is_byte(size)) begin
            return 4'b0001 << lo;
        end else if (size_is_half(size)) begin
            return lo[1] ? 4'b1100 : 4'b0011;
        end else begin
            return 4'b1111;
        end
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load lane select and extension (purely combinational).
//   raw     : 32-bit word as read from RAM / MMIO
//   size    : MEM_SIZE_* code of the load
//   addr_lo : byte address bits [1:0] of the load
//   result  : extracted, sign- or zero-extended value
module mem_load_align
    import mem_unit_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] result
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = raw[8*addr_lo +: 8];
        half_lane = addr_lo[1] ? raw[31:16] : raw[15:0];
        result    = raw;
        case (size)
            MEM_SIZE_B:  result = {{24{byte_lane[7]}}, byte_lane};
            MEM_SIZE_BU: result = {24'h0, byte_lane};
            MEM_SIZE_H:  result = {{16{half_lane[15]}}, half_lane};
            MEM_SIZE_HU: result = {16'h0, half_lane};
            default:     result = raw;
        endcase
    end

endmodule

// File: rtl/mem_unit.sv
// Shared memory unit: instruction fetch, loads and stores into a single-port RAM,
// plus an optional MMIO window (LED register, free-running cycle counter).
// Optional feature macro: MEM_MMIO_EN (undefined: MMIO window faults, led tied 0).
//   clk, rst  : clock, asynchronous active-high reset
//   unit_sel  : request accepted only when UNIT_SEL_MEM
//   unit_ctrl : [1:0] op, [4:2] size
//   unit_in0  : byte address
//   unit_in1  : store data (low-aligned)
//   unit_out  : read result, valid the cycle after a read sample, then held
//   fault     : last accepted request faulted
//   led       : MMIO LED register
module mem_unit
    import mem_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  unit_sel_t   unit_sel,
    input  logic [31:0] unit_ctrl,
    input  logic [31:0] unit_in0,
    input  logic [31:0] unit_in1,
    output logic [31:0] unit_out,
    output logic        fault,
    output logic [15:0] led
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(MEM_WORDS * 4);

    // Request decode
    logic [1:0]    op;
    logic [2:0]    size;
    logic [1:0]    lo;
    logic          is_rd, is_wr;
    logic          in_ram, in_mmio;
    region_t       region;
    logic          misalign, req_fault;
    logic [AW-1:0] ram_idx;
    logic [3:0]    be;
    logic [31:0]   wdata;
    logic          ram_we, ram_re;

    assign op      = unit_ctrl[1:0];
    assign size    = unit_ctrl[4:2];
    assign lo      = unit_in0[1:0];
    assign is_rd   = (unit_sel == UNIT_SEL_MEM) && (op == MEM_OP_READ);
    assign is_wr   = (unit_sel == UNIT_SEL_MEM) && (op == MEM_OP_WRITE);
    assign in_ram  = unit_in0 < RAM_BYTES;
    assign in_mmio = {unit_in0[31:4], 4'h0} == MMIO_BASE;
    assign ram_idx = unit_in0[AW+1:2];

`ifdef MEM_MMIO_EN
    assign region = in_ram ? REGION_RAM : (in_mmio ? REGION_MMIO : REGION_NONE);
`else
    logic unused_mmio;
    assign unused_mmio = in_mmio;
    assign region      = in_ram ? REGION_RAM : REGION_NONE;
`endif

    assign misalign  = (size_is_half(size) && lo[0]) ||
                       (!size_is_half(size) && !size_is_byte(size) && (lo != 2'b00));
    // MMIO registers only support full-word access.
    assign req_fault = misalign || (region == REGION_NONE) ||
                       ((region == REGION_MMIO) && (size_is_byte(size) || size_is_half(size)));

    assign be     = store_be(size, lo);
    assign wdata  = size_is_byte(size) ? {4{unit_in1[7:0]}} :
                    size_is_half(size) ? {2{unit_in1[15:0]}} : unit_in1;
    assign ram_we = is_wr && !req_fault && (region == REGION_RAM);
    assign ram_re = is_rd && !req_fault && (region == REGION_RAM);

    // RAM array with registered read port (no reset, so it maps onto block RAM)
    logic [31:0] mem [MEM_WORDS];
    logic [31:0] ram_q;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (ram_re) ram_q <= mem[ram_idx];
    end

    // MMIO window
    logic [31:0] mmio_q;
`ifdef MEM_MMIO_EN
    logic [15:0] led_q;
    logic [31:0] cycle_q;
    logic [3:0]  mmio_ofs;
    logic        mmio_ok;

    assign mmio_ofs = unit_in0[3:0];
    assign mmio_ok  = !req_fault && (region == REGION_MMIO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_q   <= '0;
            cycle_q <= '0;
            mmio_q  <= '0;
        end else begin
            cycle_q <= cycle_q + 32'd1;
            if (is_wr && mmio_ok && (mmio_ofs == MMIO_LED_OFS)) led_q <= unit_in1[15:0];
            if (is_rd && mmio_ok) begin
                if (mmio_ofs == MMIO_LED_OFS)        mmio_q <= {16'h0, led_q};
                else if (mmio_ofs == MMIO_CYCLE_OFS) mmio_q <= cycle_q;
                else                                 mmio_q <= '0;
            end
        end
    end

    assign led = led_q;
`else
    assign mmio_q = '0;
    assign led    = '0;
`endif

    // Pending-load descriptor; a faulted read is recorded as REGION_NONE so it yields 0.
    logic [2:0] pend_size_q;
    logic [1:0] pend_lo_q;
    region_t    pend_region_q;
    logic       fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_size_q   <= '0;
            pend_lo_q     <= '0;
            pend_region_q <= REGION_NONE;
            fault_q       <= 1'b0;
        end else begin
            if (is_rd) begin
                pend_size_q   <= size;
                pend_lo_q     <= lo;
                pend_region_q <= req_fault ? REGION_NONE : region;
            end
            if (is_rd || is_wr) fault_q <= req_fault;
        end
    end

    assign fault = fault_q;

    // Load FSM
    mem_state_t state_q, state_d;
    logic       load_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:      if (is_rd) state_d = LOAD_PEND;
            LOAD_PEND: state_d = is_rd ? LOAD_PEND : IDLE;
        endcase
    end

    always_comb begin
        load_done = (state_q == LOAD_PEND);
    end

    // Result path: the aligned RAM/MMIO register drives unit_out while a load is
    // completing and is latched into out_q so it stays put afterwards.
    logic [31:0] pend_raw, load_result, out_q;

    always_comb begin
        pend_raw = '0;
        case (pend_region_q)
            REGION_RAM:  pend_raw = ram_q;
            REGION_MMIO: pend_raw = mmio_q;
            default:     pend_raw = '0;
        endcase
    end

    mem_load_align u_align (
        .raw     (pend_raw),
        .size    (pend_size_q),
        .addr_lo (pend_lo_q),
        .result  (load_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            out_q <= '0;
        else if (load_done) out_q <= load_result;
    end

    assign unit_out = load_done ? load_result : out_q;

endmodule

// File: tb/tb_mem_unit.sv
// Self-checking bench for mem_unit: directed cases plus randomized requests checked
// against a byte-level reference model.
module tb_mem_unit;
    import mem_unit_pkg::*;

    localparam logic [31:0] RAM_BYTES = 32'h0000_1000;
    localparam logic [31:0] MMIO_BASE = 32'h8000_0000;
`ifdef MEM_MMIO_EN
    localparam bit MMIO_EN = 1'b1;
`else
    localparam bit MMIO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    unit_sel_t   unit_sel = UNIT_SEL_NONE;
    logic [31:0] unit_ctrl = '0;
    logic [31:0] unit_in0 = '0;
    logic [31:0] unit_in1 = '0;
    logic [31:0] unit_out;
    logic        fault;
    logic [15:0] led;

    mem_unit dut (
        .clk       (clk),
        .rst       (rst),
        .unit_sel  (unit_sel),
        .unit_ctrl (unit_ctrl),
        .unit_in0  (unit_in0),
        .unit_in1  (unit_in1),
        .unit_out  (unit_out),
        .fault     (fault),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Edges seen since reset release: the value the cycle counter holds at the next edge.
    logic [31:0] cyc_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc_cnt <= '0;
        else     cyc_cnt <= cyc_cnt + 32'd1;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] mdl_mem [1024];
    logic [31:0] exp_out   = '0;
    logic        exp_fault = 1'b0;
    logic [15:0] exp_led   = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request cycle; the model is updated and the DUT outputs checked 1 time unit
    // after the sampling edge.
    task automatic req(input unit_sel_t sel, input logic [1:0] op, input logic [2:0] sz,
                       input logic [31:0] addr, input logic [31:0] data, input string tag);
        logic [31:0] junk, snap, val, b_addr;
        int unsigned width;
        bit          sgn, in_ram, in_mmio, flt;
        @(negedge clk);
        junk      = $urandom();
        unit_sel  = sel;
        unit_ctrl = {junk[31:5], sz, op};
        unit_in0  = addr;
        unit_in1  = data;
        snap      = cyc_cnt;
        @(posedge clk);
        #1;
        if (sel == UNIT_SEL_MEM && (op == 2'd1 || op == 2'd2)) begin
            width   = (sz == 3'd0 || sz == 3'd4) ? 1 : (sz == 3'd1 || sz == 3'd5) ? 2 : 4;
            sgn     = (sz == 3'd0 || sz == 3'd1);
            in_ram  = addr < RAM_BYTES;
            in_mmio = MMIO_EN && (addr >= MMIO_BASE) && (addr - MMIO_BASE < 32'd16);
            flt     = (addr % width != 0) || (!in_ram && !in_mmio) || (in_mmio && width != 4);
            exp_fault = flt;
            if (op == 2'd1) begin
                val = '0;
                if (!flt && in_ram) begin
                    for (int k = 0; k < int'(width); k++) begin
                        b_addr = addr + 32'(k);
                        val |= 32'(mdl_mem[b_addr[11:2]][8*b_addr[1:0] +: 8]) << (8 * k);
                    end
                    if (sgn && width < 4 && val[8*width-1]) val |= 32'hFFFF_FFFF << (8 * width);
                end else if (!flt && in_mmio) begin
                    if (addr - MMIO_BASE == 32'd0)      val = {16'h0, exp_led};
                    else if (addr - MMIO_BASE == 32'd4) val = snap;
                end
                exp_out = val;
            end else if (!flt) begin
                if (in_ram) begin
                    for (int k = 0; k < int'(width); k++) begin
                        b_addr = addr + 32'(k);
                        mdl_mem[b_addr[11:2]][8*b_addr[1:0] +: 8] = data[8*k +: 8];
                    end
                end else if (addr - MMIO_BASE == 32'd0) begin
                    exp_led = data[15:0];
                end
            end
        end
        check({tag, "/out"}, unit_out, exp_out);
        check({tag, "/fault"}, {31'h0, fault}, {31'h0, exp_fault});
        check({tag, "/led"}, {16'h0, led}, {16'h0, exp_led});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] v1, v2, addr;
        int          kind;
        unit_sel_t   sel;

        #2;
        check("rst/out", unit_out, 32'h0);
        check("rst/fault", {31'h0, fault}, 32'h0);
        check("rst/led", {16'h0, led}, 32'h0);
        #10 rst = 1'b0;

        // Known contents for every RAM address the random phase can read
        for (int a = 0; a < 64; a += 4)
            req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_W, 32'(a), $urandom(), "init_lo");
        for (int a = 32'hFC0; a < 32'h1000; a += 4)
            req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_W, 32'(a), $urandom(), "init_hi");

        req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_W, 32'h10, 32'h1122_3344, "sw");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "lw_a");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "lw_b");
        check("lw_b/const", unit_out, 32'h1122_3344);
        check("lw_b/fault0", {31'h0, fault}, 32'h0);

        req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_B, 32'h13, 32'h0000_00AB, "sb");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_B, 32'h13, 32'h0, "lb");
        check("lb/const", unit_out, 32'hFFFF_FFAB);
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_BU, 32'h13, 32'h0, "lbu");
        check("lbu/const", unit_out, 32'h0000_00AB);
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "lw_merged");
        check("lw_merged/const", unit_out, 32'hAB22_3344);

        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_H, 32'h11, 32'h0, "lh_mis");
        check("lh_mis/const", {unit_out[31:1], fault}, 32'h1);
        req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_W, 32'h12, 32'hDEAD_BEEF, "sw_mis");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "lw_after_mis");
        check("sw_mis/suppressed", unit_out, 32'hAB22_3344);

        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h1000, 32'h0, "oob");
        check("oob/fault1", {31'h0, fault}, 32'h1);
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "oob_clear");
        req(UNIT_SEL_ALU, MEM_OP_READ, MEM_SIZE_W, 32'h1000, 32'h0, "not_sel");
        req(UNIT_SEL_MEM, 2'd3, MEM_SIZE_W, 32'h1000, 32'h0, "op3");
        check("op3/hold", unit_out, 32'hAB22_3344);

`ifdef MEM_MMIO_EN
        req(UNIT_SEL_MEM, MEM_OP_WRITE, MEM_SIZE_W, MMIO_BASE, 32'h0001_BEEF, "led_wr");
        check("led_wr/const", {16'h0, led}, 32'h0000_BEEF);
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, MMIO_BASE + 32'd4, 32'h0, "cyc_a");
        v1 = unit_out;
        for (int i = 0; i < 4; i++) req(UNIT_SEL_NONE, MEM_OP_NONE, MEM_SIZE_W, 32'h0, 32'h0, "gap");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, MMIO_BASE + 32'd4, 32'h0, "cyc_b");
        v2 = unit_out;
        check("cyc/delta", v2 - v1, 32'd5);
`endif

        // Reset while a load is pending
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h14, 32'h0, "pre_rst");
        rst = 1'b1;
        #1;
        check("mid_rst/out", unit_out, 32'h0);
        check("mid_rst/fault", {31'h0, fault}, 32'h0);
        check("mid_rst/led", {16'h0, led}, 32'h0);
        exp_out   = '0;
        exp_fault = 1'b0;
        exp_led   = '0;
        unit_sel  = UNIT_SEL_NONE;
        @(negedge clk);
        rst = 1'b0;
        req(UNIT_SEL_NONE, MEM_OP_NONE, MEM_SIZE_W, 32'h0, 32'h0, "post_rst_idle");
        req(UNIT_SEL_MEM, MEM_OP_READ, MEM_SIZE_W, 32'h10, 32'h0, "post_rst_lw");
        check("post_rst_lw/const", unit_out, 32'hAB22_3344);

        for (int n = 0; n < 500; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 5)      addr = 32'($urandom_range(0, 63));
            else if (kind <= 7) addr = 32'($urandom_range(32'hFC0, 32'h1007));
            else if (kind == 8) addr = MMIO_BASE + 32'($urandom_range(0, 19));
            else                addr = $urandom() | 32'h0001_0000;
            sel = ($urandom_range(0, 3) != 0) ? UNIT_SEL_MEM : unit_sel_t'($urandom_range(0, 3));
            req(sel, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), addr, $urandom(), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
